// File: rtl/sync_arb_ctrl.sv
// Round-robin arbiter that time-shares one multi-stage synchronizer between
// NREQ requesters, re-tagging each synchronized payload with its requester id.
module sync_arb_ctrl #(
  parameter  int DW    = 4,
  parameter  int STAGE = 3,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_srst,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [NREQ*DW-1:0] i_req_data,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [NREQ-1:0]   i_cfg_en,
  input  logic              i_flush,
  output logic [DW-1:0]     o_sync_din,
  input  logic [DW-1:0]     i_sync_dout,
  output logic              o_rsp_valid,
  output logic [IDW-1:0]    o_rsp_id,
  output logic [DW-1:0]     o_rsp_data,
  output logic              o_flush_done,
  output logic              o_busy
);

  typedef enum logic [1:0] {RUN, DRAIN, HOLD} ArbState;

  ArbState          r_state;
  logic             r_flushDone;
  logic [IDW-1:0]   r_rrPtr;
  logic [NREQ-1:0]  r_inFlight;
  logic [STAGE-1:0] r_tagValid;
  logic [IDW-1:0]   r_tagId [STAGE];

  logic [NREQ-1:0]  w_clear;
  logic [NREQ-1:0]  w_eligible;
  logic [NREQ-1:0]  w_grantVec;
  logic             w_grant;
  logic [IDW-1:0]   w_grantId;
  logic [IDW-1:0]   w_nextPtr;
  logic [IDW:0]     w_search;
  logic [IDW-1:0]   w_idx;
  logic             w_rspValid;
  logic [IDW-1:0]   w_rspId;
  logic             w_pipeDrained;

  assign w_rspValid = r_tagValid[STAGE-1];
  assign w_rspId    = r_tagId[STAGE-1];

  // With grants stopped, the pipe is empty after this edge once only the last stage may hold a tag.
  assign w_pipeDrained = ~|r_tagValid[STAGE-2:0];

  // A requester whose tag is being delivered this cycle may be granted again at once.
  always_comb begin
    w_clear    = '0;
    w_eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_clear[i]    = w_rspValid && (w_rspId == IDW'(i));
      w_eligible[i] = i_req_valid[i] && i_cfg_en[i] && (!r_inFlight[i] || w_clear[i]);
    end
    if (!rst_n || i_srst || i_flush || (r_state != RUN)) begin
      w_eligible = '0;
    end
  end

  always_comb begin
    w_grant   = 1'b0;
    w_grantId = '0;
    w_search  = '0;
    w_idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_search = {1'b0, r_rrPtr} + (IDW+1)'(k);
      if (w_search >= (IDW+1)'(NREQ)) begin
        w_search = w_search - (IDW+1)'(NREQ);
      end
      w_idx = w_search[IDW-1:0];
      if (!w_grant && w_eligible[w_idx]) begin
        w_grant   = 1'b1;
        w_grantId = w_idx;
      end
    end
  end

  assign w_grantVec = w_grant ? (NREQ'(1) << w_grantId) : '0;
  assign w_nextPtr  = (w_grantId == IDW'(NREQ-1)) ? '0 : w_grantId + IDW'(1);

  always_comb begin
    o_sync_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grantVec[i]) begin
        o_sync_din = i_req_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr    <= '0;
      r_inFlight <= '0;
      r_tagValid <= '0;
      for (int s = 0; s < STAGE; s++) begin
        r_tagId[s] <= '0;
      end
    end else if (i_srst) begin
      r_rrPtr    <= '0;
      r_inFlight <= '0;
      r_tagValid <= '0;
      for (int s = 0; s < STAGE; s++) begin
        r_tagId[s] <= '0;
      end
    end else begin
      if (w_grant) begin
        r_rrPtr <= w_nextPtr;
      end
      r_inFlight <= (r_inFlight & ~w_clear) | w_grantVec;
      r_tagValid <= {r_tagValid[STAGE-2:0], w_grant};
      r_tagId[0] <= w_grantId;
      for (int s = 1; s < STAGE; s++) begin
        r_tagId[s] <= r_tagId[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_flushDone <= 1'b0;
    end else if (i_srst) begin
      r_state     <= RUN;
      r_flushDone <= 1'b0;
    end else begin
      r_flushDone <= 1'b0;
      case (r_state)
        RUN: begin
          if (i_flush) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_pipeDrained) begin
            r_state     <= HOLD;
            r_flushDone <= 1'b1;
          end
        end
        HOLD: begin
          if (!i_flush) begin
            r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign o_req_ready  = w_grantVec;
  assign o_rsp_valid  = w_rspValid;
  assign o_rsp_id     = w_rspId;
  assign o_rsp_data   = w_rspValid ? i_sync_dout : '0;
  assign o_flush_done = r_flushDone;
  assign o_busy       = |r_tagValid;

endmodule

// File: tb/tb_sync_arb_ctrl.sv
// Directed bench for sync_arb_ctrl: 4 requesters sharing a 3-flop synchronizer,
// covering reset, round-robin order, flush/drain, sync clear and enable masking.
module tb_sync_arb_ctrl;

  logic        clk;
  logic        rst_n;
  logic        srst;
  logic [3:0]  reqValid;
  logic [15:0] reqData;
  logic [3:0]  reqReady;
  logic [3:0]  cfgEn;
  logic        flush;
  logic [3:0]  syncDin;
  logic [3:0]  syncDout;
  logic        rspValid;
  logic [1:0]  rspId;
  logic [3:0]  rspData;
  logic        flushDone;
  logic        busy;

  int checks;
  int errors;

  logic [3:0] syncS0, syncS1, syncS2;

  sync_arb_ctrl #(.DW(4), .STAGE(3), .NREQ(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_srst       (srst),
    .i_req_valid  (reqValid),
    .i_req_data   (reqData),
    .o_req_ready  (reqReady),
    .i_cfg_en     (cfgEn),
    .i_flush      (flush),
    .o_sync_din   (syncDin),
    .i_sync_dout  (syncDout),
    .o_rsp_valid  (rspValid),
    .o_rsp_id     (rspId),
    .o_rsp_data   (rspData),
    .o_flush_done (flushDone),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three-flop synchronizer stand-in, cleared by both resets like the real one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncS0 <= '0;
      syncS1 <= '0;
      syncS2 <= '0;
    end else if (srst) begin
      syncS0 <= '0;
      syncS1 <= '0;
      syncS2 <= '0;
    end else begin
      syncS0 <= syncDin;
      syncS1 <= syncS0;
      syncS2 <= syncS1;
    end
  end
  assign syncDout = syncS2;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [15:0] d, input logic [3:0] e,
                               input logic f, input logic s);
    reqValid = v;
    reqData  = d;
    cfgEn    = e;
    flush    = f;
    srst     = s;
  endtask

  // Drives one cycle's inputs, checks outputs mid-cycle, then advances past the next edge.
  task automatic runCycle(input string tag, input logic [3:0] v, input logic [15:0] d,
                          input logic [3:0] e, input logic f, input logic s,
                          input logic [3:0] xReady, input logic xRv, input logic [1:0] xId,
                          input logic [3:0] xData, input logic xBusy, input logic xDone);
    logic [3:0] xDin;
    applyStimulus(v, d, e, f, s);
    xDin = '0;
    for (int i = 0; i < 4; i++) begin
      if (xReady[i]) xDin = d[i*4 +: 4];
    end
    @(negedge clk);
    checkOutput({tag, ".ready"}, 32'(reqReady), 32'(xReady));
    checkOutput({tag, ".syncdin"}, 32'(syncDin), 32'(xDin));
    checkOutput({tag, ".rspvalid"}, 32'(rspValid), 32'(xRv));
    if (xRv) checkOutput({tag, ".rspid"}, 32'(rspId), 32'(xId));
    checkOutput({tag, ".rspdata"}, 32'(rspData), 32'(xData));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(xBusy));
    checkOutput({tag, ".flushdone"}, 32'(flushDone), 32'(xDone));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(4'hF, 16'h4321, 4'hF, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.ready", 32'(reqReady), 32'h0);
    checkOutput("rst.rspvalid", 32'(rspValid), 32'h0);
    checkOutput("rst.rspid", 32'(rspId), 32'h0);
    checkOutput("rst.flushdone", 32'(flushDone), 32'h0);
    checkOutput("rst.busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] all requesters valid from reset");
    runCycle("c0",  4'hF, 16'h4321, 4'hF, 0, 0, 4'h1, 0, 0, 4'h0, 0, 0);
    runCycle("c1",  4'hF, 16'h4321, 4'hF, 0, 0, 4'h2, 0, 0, 4'h0, 1, 0);
    runCycle("c2",  4'hF, 16'h4321, 4'hF, 0, 0, 4'h4, 0, 0, 4'h0, 1, 0);
    runCycle("c3",  4'hF, 16'h4321, 4'hF, 0, 0, 4'h8, 1, 0, 4'h1, 1, 0);
    runCycle("c4",  4'hF, 16'h4321, 4'hF, 0, 0, 4'h1, 1, 1, 4'h2, 1, 0);
    runCycle("c5",  4'hF, 16'h4321, 4'hF, 0, 0, 4'h2, 1, 2, 4'h3, 1, 0);
    runCycle("c6",  4'hF, 16'h4321, 4'hF, 0, 0, 4'h4, 1, 3, 4'h4, 1, 0);
    runCycle("c7",  4'hF, 16'h4321, 4'hF, 0, 0, 4'h8, 1, 0, 4'h1, 1, 0);
    runCycle("c8",  4'h0, 16'h4321, 4'hF, 0, 0, 4'h0, 1, 1, 4'h2, 1, 0);
    runCycle("c9",  4'h0, 16'h4321, 4'hF, 0, 0, 4'h0, 1, 2, 4'h3, 1, 0);
    runCycle("c10", 4'h0, 16'h4321, 4'hF, 0, 0, 4'h0, 1, 3, 4'h4, 1, 0);
    runCycle("c11", 4'h0, 16'h4321, 4'hF, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0);

    $display("[TB] single transfer from requester 2");
    runCycle("c12", 4'h4, 16'h0A00, 4'hF, 0, 0, 4'h4, 0, 0, 4'h0, 0, 0);
    runCycle("c13", 4'h0, 16'h0A00, 4'hF, 0, 0, 4'h0, 0, 0, 4'h0, 1, 0);
    runCycle("c14", 4'h0, 16'h0A00, 4'hF, 0, 0, 4'h0, 0, 0, 4'h0, 1, 0);
    runCycle("c15", 4'h0, 16'h0A00, 4'hF, 0, 0, 4'h0, 1, 2, 4'hA, 1, 0);

    $display("[TB] flush with two transfers in flight");
    runCycle("c16", 4'hF, 16'h4321, 4'hF, 0, 0, 4'h8, 0, 0, 4'h0, 0, 0);
    runCycle("c17", 4'hF, 16'h4321, 4'hF, 0, 0, 4'h1, 0, 0, 4'h0, 1, 0);
    runCycle("c18", 4'hF, 16'h4321, 4'hF, 1, 0, 4'h0, 0, 0, 4'h0, 1, 0);
    runCycle("c19", 4'hF, 16'h4321, 4'hF, 1, 0, 4'h0, 1, 3, 4'h4, 1, 0);
    runCycle("c20", 4'hF, 16'h4321, 4'hF, 1, 0, 4'h0, 1, 0, 4'h1, 1, 0);
    runCycle("c21", 4'hF, 16'h4321, 4'hF, 1, 0, 4'h0, 0, 0, 4'h0, 0, 1);
    runCycle("c22", 4'hF, 16'h4321, 4'hF, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0);
    runCycle("c23", 4'hF, 16'h4321, 4'hF, 0, 0, 4'h2, 0, 0, 4'h0, 0, 0);
    runCycle("c24", 4'h0, 16'h4321, 4'hF, 0, 0, 4'h0, 0, 0, 4'h0, 1, 0);
    runCycle("c25", 4'h0, 16'h4321, 4'hF, 0, 0, 4'h0, 0, 0, 4'h0, 1, 0);
    runCycle("c26", 4'h0, 16'h4321, 4'hF, 0, 0, 4'h0, 1, 1, 4'h2, 1, 0);
    runCycle("c27", 4'h0, 16'h4321, 4'hF, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0);

    $display("[TB] synchronous clear after a grant");
    runCycle("c28", 4'h1, 16'h4321, 4'hF, 0, 0, 4'h1, 0, 0, 4'h0, 0, 0);
    runCycle("c29", 4'h0, 16'h4321, 4'hF, 0, 1, 4'h0, 0, 0, 4'h0, 1, 0);
    runCycle("c30", 4'hF, 16'h4321, 4'hF, 0, 0, 4'h1, 0, 0, 4'h0, 0, 0);
    runCycle("c31", 4'h0, 16'h4321, 4'hF, 0, 0, 4'h0, 0, 0, 4'h0, 1, 0);
    runCycle("c32", 4'h0, 16'h4321, 4'hF, 0, 0, 4'h0, 0, 0, 4'h0, 1, 0);
    runCycle("c33", 4'h0, 16'h4321, 4'hF, 0, 0, 4'h0, 1, 0, 4'h1, 1, 0);

    $display("[TB] enable mask and mid-flight disable");
    runCycle("c34", 4'hF, 16'h4321, 4'hE, 0, 0, 4'h2, 0, 0, 4'h0, 0, 0);
    runCycle("c35", 4'hF, 16'h4321, 4'hE, 0, 0, 4'h4, 0, 0, 4'h0, 1, 0);
    runCycle("c36", 4'hF, 16'h4321, 4'hE, 0, 0, 4'h8, 0, 0, 4'h0, 1, 0);
    runCycle("c37", 4'hF, 16'h4321, 4'h6, 0, 0, 4'h2, 1, 1, 4'h2, 1, 0);
    runCycle("c38", 4'hF, 16'h4321, 4'h6, 0, 0, 4'h4, 1, 2, 4'h3, 1, 0);
    runCycle("c39", 4'hF, 16'h4321, 4'h6, 0, 0, 4'h0, 1, 3, 4'h4, 1, 0);
    runCycle("c40", 4'hF, 16'h4321, 4'h6, 0, 0, 4'h2, 1, 1, 4'h2, 1, 0);
    runCycle("c41", 4'h0, 16'h4321, 4'hF, 0, 0, 4'h0, 1, 2, 4'h3, 1, 0);
    runCycle("c42", 4'h0, 16'h4321, 4'hF, 0, 0, 4'h0, 0, 0, 4'h0, 1, 0);
    runCycle("c43", 4'h0, 16'h4321, 4'hF, 0, 0, 4'h0, 1, 1, 4'h2, 1, 0);

    $display("[TB] flush with empty pipe");
    runCycle("c44", 4'hF, 16'h4321, 4'hF, 1, 0, 4'h0, 0, 0, 4'h0, 0, 0);
    runCycle("c45", 4'hF, 16'h4321, 4'hF, 1, 0, 4'h0, 0, 0, 4'h0, 0, 0);
    runCycle("c46", 4'hF, 16'h4321, 4'hF, 0, 0, 4'h0, 0, 0, 4'h0, 0, 1);
    runCycle("c47", 4'hF, 16'h4321, 4'hF, 0, 0, 4'h4, 0, 0, 4'h0, 0, 0);
    runCycle("c48", 4'h0, 16'h4321, 4'hF, 0, 0, 4'h0, 0, 0, 4'h0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
